// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN_DEFAULT     : address/data width the fetch entry payload is built for
//   RESET_PC_DEFAULT : PC loaded on reset
//   J_*              : jump-type encodings driven by the control unit
//   fetch_state_t    : request/response tracking state
//   fetch_entry_t    : one buffered instruction with its PC
package fetch_pkg;

    localparam int unsigned     XLEN_DEFAULT     = 32;
    localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all entries (takes priority over push/pop)
//   push/push_data : write one entry; accepted when not full or when popping
//   pop        : remove the head entry; ignored when empty
//   head_c     : current head entry (combinational read of registered storage)
//   count      : number of valid entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  fetch_entry_t                  push_data,
    input  logic                          pop,
    output fetch_entry_t                  head_c,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word request
// to instruction memory, buffers responses and hands them to decode with
// their PC. Taken branches, JAL and JALR redirect the PC and flush wrong-path
// work.
//   clk, rst                      : clock, synchronous active-high reset
//   ex_valid, PCSrc, J            : redirect qualifiers from control
//   TargetAddr, JalrTarget        : branch/JAL and JALR targets
//   imem_req_*                    : request channel (valid/ready, word address)
//   imem_rsp_*                    : response channel (always accepted)
//   instr_valid/ready, instr, instr_pc : decode-side handoff
// XLEN must match the width of fetch_entry_t in fetch_pkg.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            PCSrc,
    input  logic [1:0]      J,
    input  logic [XLEN-1:0] TargetAddr,
    input  logic [XLEN-1:0] JalrTarget,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic            req_fire_c;
    logic            push_c;
    fetch_entry_t    push_data_c;
    fetch_entry_t    head_c;
    logic [CNT_W-1:0] fifo_count;

    // Redirect decode; JALR targets have bit 0 cleared.
    always_comb begin
        redirect_c = ex_valid && (PCSrc || (J == J_JAL) || (J == J_JALR));
        target_c   = (J == J_JALR) ? (JalrTarget & ~XLEN'(1)) : TargetAddr;
    end

    // Request only with no outstanding fetch and a free slot for its response;
    // a redirect withdraws any unaccepted request.
    assign imem_req_valid = !rst && (state_q == IDLE) && !redirect_c &&
                            (fifo_count < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire_c     = imem_req_valid && imem_req_ready;

    // Next-state, PC and buffer-push logic.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        req_pc_d          = req_pc_q;
        push_c            = 1'b0;
        push_data_c.pc    = req_pc_q;
        push_data_c.instr = imem_rsp_data;
        if (redirect_c) begin
            pc_d = target_c;
        end
        unique case (state_q)
            IDLE: begin
                if (req_fire_c) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push_c  = !redirect_c;
                    state_d = IDLE;
                end else if (redirect_c) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                // Leave only when the stale response has been absorbed.
                if (imem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_c),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (instr_valid && instr_ready),
        .head_c    (head_c),
        .count     (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = head_c.instr;
    assign instr_pc    = head_c.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests, the
// stimulus pushes hand-computed expected {pc, instr} pairs, and a monitor
// compares every instruction decode consumes against the queue front.
module tb_fetch_unit;

    logic        clk;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        PCSrc = 1'b0;
    logic [1:0]  J = 2'b00;
    logic [31:0] TargetAddr = '0;
    logic [31:0] JalrTarget = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(.FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .PCSrc          (PCSrc),
        .J              (J),
        .TargetAddr     (TargetAddr),
        .JalrTarget     (JalrTarget),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_chk   = 0;
    int unsigned n_pass  = 0;
    int unsigned pop_cnt = 0;
    int unsigned req_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] last_req_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_instr(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Memory model: request accepted at the edge after a valid&ready negedge,
    // response driven mem_lat cycles later for one cycle.
    always begin
        logic [31:0] a;
        @(negedge clk);
        if (!rst && imem_req_valid && imem_req_ready) begin
            a = imem_req_addr;
            last_req_addr = a;
            req_cnt++;
            @(posedge clk);
            repeat (mem_lat - 1) @(posedge clk);
            #1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(a);
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Monitor: every instruction consumed by decode must match the queue front.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected nothing", instr_pc, instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_instr", instr, e.data);
            end
            pop_cnt++;
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int unsigned target);
        int unsigned n;
        n = 0;
        while (pop_cnt < target && n < 100) begin
            sample();
            n++;
        end
        n_chk++;
        if (pop_cnt >= target) n_pass++;
        else $display("FAIL wait_pops: popped %0d expected %0d", pop_cnt, target);
    endtask

    task automatic wait_req(input int unsigned target);
        int unsigned n;
        n = 0;
        while (req_cnt < target && n < 100) begin
            sample();
            n++;
        end
        n_chk++;
        if (req_cnt >= target) n_pass++;
        else $display("FAIL wait_req: requests %0d expected %0d", req_cnt, target);
    endtask

    // Let decode consume exactly n instructions.
    task automatic drain(input int unsigned n);
        int unsigned target;
        target = pop_cnt + n;
        @(posedge clk);
        #1 instr_ready = 1'b1;
        wait_pops(target);
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    initial begin
        int unsigned base;

        // Reset state.
        repeat (3) @(posedge clk);
        sample();
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // First request right after reset; decode stalled fills the buffer.
        @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        repeat (8) sample();
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_req_addr", imem_req_addr, 32'h8);
        check("full_instr_valid", 32'(instr_valid), 32'd1);
        check("full_head_pc", instr_pc, 32'h0);
        check("full_head_instr", instr, mem_word(32'h0));

        // Release decode: stream 0, 4, 8.
        expect_instr(32'h0);
        expect_instr(32'h4);
        expect_instr(32'h8);
        drain(3);
        settle();

        // Memory not ready: request to 0x14 held stable.
        imem_req_ready = 1'b0;
        expect_instr(32'hC);
        drain(1);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check("stall_req_addr", imem_req_addr, 32'h14);
        end
        @(posedge clk);
        #1 imem_req_ready = 1'b1;
        settle();

        // Branch redirect while waiting; response arrives a cycle later.
        mem_lat = 2;
        expect_instr(32'h10);
        base = req_cnt;
        drain(1);
        wait_req(base + 1);
        @(posedge clk);
        #1;
        ex_valid = 1'b1; PCSrc = 1'b1; TargetAddr = 32'h100;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; PCSrc = 1'b0; TargetAddr = '0;
        sample();
        check("br_discard_req_valid", 32'(imem_req_valid), 32'd0);
        check("br_flush_instr_valid", 32'(instr_valid), 32'd0);
        wait_req(base + 2);
        check("br_target_req", last_req_addr, 32'h100);
        settle();
        expect_instr(32'h100);
        drain(1);
        settle();
        mem_lat = 1;

        // JALR redirect coincident with a response.
        expect_instr(32'h104);
        base = req_cnt;
        drain(1);
        wait_req(base + 1);
        @(posedge clk);
        #1;
        ex_valid = 1'b1; J = 2'b10; JalrTarget = 32'h203; TargetAddr = 32'hDEAD_BEE0;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; J = 2'b00; JalrTarget = '0; TargetAddr = '0;
        sample();
        check("jalr_req_valid", 32'(imem_req_valid), 32'd1);
        check("jalr_req_addr", imem_req_addr, 32'h202);
        check("jalr_flush_instr_valid", 32'(instr_valid), 32'd0);
        settle();
        expect_instr(32'h202);
        drain(1);
        settle();

        // J=11 and an unqualified PCSrc do not redirect.
        @(posedge clk);
        #1;
        ex_valid = 1'b1; J = 2'b11; PCSrc = 1'b0; TargetAddr = 32'h300; JalrTarget = 32'h401;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; J = 2'b00; PCSrc = 1'b1;
        @(posedge clk);
        #1;
        PCSrc = 1'b0; TargetAddr = '0; JalrTarget = '0;
        sample();
        check("nojmp_instr_valid", 32'(instr_valid), 32'd1);
        check("nojmp_head_pc", instr_pc, 32'h206);
        check("nojmp_req_addr", imem_req_addr, 32'h20E);

        // Redirect from IDLE near the top of the address space; PC wraps.
        @(posedge clk);
        #1;
        ex_valid = 1'b1; PCSrc = 1'b1; TargetAddr = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; PCSrc = 1'b0; TargetAddr = '0;
        sample();
        check("wrap_instr_valid", 32'(instr_valid), 32'd0);
        check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        settle();
        expect_instr(32'hFFFF_FFFC);
        expect_instr(32'h0);
        drain(2);
        settle();

        // Reset with a full buffer.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check("rst2_instr_valid", 32'(instr_valid), 32'd0);
        check("rst2_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst2_req_addr", imem_req_addr, 32'h0);
        check("rst2_instr_pc", instr_pc, 32'h0);
        settle();
        expect_instr(32'h0);
        expect_instr(32'h4);
        drain(2);
        settle();

        check("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
